gate_truth_table_seq: RTL and testbench

//   Self-sequencing, parametrised N-input logic-gate exerciser. On a start pulse it

---
 rtl/gate_truth_table_seq.sv | 241 ++++++++++++++++++++++++
 tb/tb_gate_truth_table_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_table_seq.sv
`default_nettype none
// ============================================================================
// Module   : gate_truth_table_seq
// Purpose  : Self-sequencing N-input logic-gate exerciser. A start pulse
//            launches a sweep of every input combination 0..2^N_IN-1 through
//            the selected gate function. Each combination is held for
//            HOLD_CYCLES clocks and the gate output is captured into a
//            truth-table vector (tt[i] = gate output for input i).
//
// Parameters:
//   N_IN         gate input count, legal 1..5
//   HOLD_CYCLES  clocks each combination is held, legal >= 1
//   TT_W         truth-table width, fixed at 2**N_IN
//
// Ports:
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous active-high reset
//   start        in   1      begin a sweep, sampled only in IDLE
//   op           in   3      gate select, captured on accepted start
//                            0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR,
//                            6 BUF(in_vec[0]), 7 NOT(in_vec[0])
//   busy         out  1      high while the sweep is running
//   done         out  1      one-cycle pulse when the sweep completes
//   in_vec       out  N_IN   input combination currently driven to the gate
//   y            out  1      combinational gate output for in_vec
//   tt           out  TT_W   captured truth table
//   expected_tt  in   TT_W   golden truth table   (GATE_TT_COMPARE_EN only)
//   mismatch     out  1      sticky compare fail  (GATE_TT_COMPARE_EN only)
//
// Build option:
//   GATE_TT_COMPARE_EN  when defined, adds expected_tt/mismatch and the
//                       end-of-sweep truth-table compare.
//
// Revision : 1.0  initial release
// ============================================================================
module gate_truth_table_seq #(
    parameter  int N_IN        = 2,
    parameter  int HOLD_CYCLES = 10,
    localparam int TT_W        = 2 ** N_IN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    output logic            busy,
    output logic            done,
    output logic [N_IN-1:0] in_vec,
    output logic            y,
`ifdef GATE_TT_COMPARE_EN
    output logic [TT_W-1:0] tt,
    input  logic [TT_W-1:0] expected_tt,
    output logic            mismatch
`else
    output logic [TT_W-1:0] tt
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Hold counter needs at least one bit even when HOLD_CYCLES == 1.
    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [HC_W-1:0] c_HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [HC_W-1:0] c_HOLD_ONE  = HC_W'(1);

    // idx carries one extra bit so the last-index compare can never alias
    // back to zero.
    localparam logic [N_IN:0] c_IDX_LAST = (N_IN + 1)'(TT_W - 1);
    localparam logic [N_IN:0] c_IDX_ONE  = (N_IN + 1)'(1);

    localparam logic [2:0] c_OP_AND  = 3'd0;
    localparam logic [2:0] c_OP_OR   = 3'd1;
    localparam logic [2:0] c_OP_XOR  = 3'd2;
    localparam logic [2:0] c_OP_NAND = 3'd3;
    localparam logic [2:0] c_OP_NOR  = 3'd4;
    localparam logic [2:0] c_OP_XNOR = 3'd5;
    localparam logic [2:0] c_OP_BUF  = 3'd6;
    localparam logic [2:0] c_OP_NOT  = 3'd7;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [2:0]      r_op_q;
    logic [N_IN:0]   r_idx;
    logic [HC_W-1:0] r_hold_cnt;
    logic [TT_W-1:0] r_tt;

    logic            w_y;
    logic            w_hold_last;
    logic            w_idx_last;
    logic            w_start_ok;
    logic [TT_W-1:0] w_tt_next;

    assign w_hold_last = (r_hold_cnt == c_HOLD_LAST);
    assign w_idx_last  = (r_idx == c_IDX_LAST);
    assign w_start_ok  = (r_state == c_ST_IDLE) && start;

    // ------------------------------------------------------------------------
    // Gate function under test. Uses the captured op so that op changes
    // after acceptance cannot disturb a running sweep.
    // ------------------------------------------------------------------------
    always_comb begin
        w_y = 1'b0;
        case (r_op_q)
            c_OP_AND:  w_y =  (&in_vec);
            c_OP_OR:   w_y =  (|in_vec);
            c_OP_XOR:  w_y =  (^in_vec);
            c_OP_NAND: w_y = ~(&in_vec);
            c_OP_NOR:  w_y = ~(|in_vec);
            c_OP_XNOR: w_y = ~(^in_vec);
            c_OP_BUF:  w_y =   in_vec[0];
            c_OP_NOT:  w_y =  ~in_vec[0];
            default:   w_y = 1'b0;
        endcase
    end

    // Truth table with the current gate output merged in at idx. This is
    // what gets written on a capture cycle, and also what the optional
    // compare sees, so the final bit is included in the comparison.
    always_comb begin
        w_tt_next                      = r_tt;
        w_tt_next[r_idx[N_IN-1:0]]     = w_y;
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and status outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_next = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                busy = 1'b1;
                if (w_hold_last && w_idx_last) begin
                    w_state_next = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                done         = 1'b1;
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Sweep datapath: op capture, hold counter, index and truth table.
    // idx and tt are left untouched in DONE/IDLE so in_vec and tt hold
    // their final values until the next accepted start.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_q     <= 3'd0;
            r_idx      <= '0;
            r_hold_cnt <= '0;
            r_tt       <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_op_q     <= op;
                        r_idx      <= '0;
                        r_hold_cnt <= '0;
                        r_tt       <= '0;
                    end
                end
                c_ST_RUN: begin
                    if (w_hold_last) begin
                        r_tt       <= w_tt_next;
                        r_hold_cnt <= '0;
                        if (!w_idx_last) begin
                            r_idx <= r_idx + c_IDX_ONE;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + c_HOLD_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_vec = r_idx[N_IN-1:0];
    assign y      = w_y;
    assign tt     = r_tt;

`ifdef GATE_TT_COMPARE_EN
    // ------------------------------------------------------------------------
    // End-of-sweep compare. Evaluated on the edge that enters DONE, using
    // the truth table including the bit captured on that same edge. The
    // flag stays set until the next accepted start or reset.
    // ------------------------------------------------------------------------
    logic r_mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mismatch <= 1'b0;
        end else if (w_start_ok) begin
            r_mismatch <= 1'b0;
        end else if ((r_state == c_ST_RUN) && w_hold_last && w_idx_last) begin
            r_mismatch <= (w_tt_next != expected_tt);
        end
    end

    assign mismatch = r_mismatch;
`else
    // Start acceptance only matters to the compare logic; keep the term
    // referenced so the default build stays warning-free.
    logic w_unused;
    assign w_unused = w_start_ok;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gate_truth_table_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_truth_table_seq
// Purpose  : Self-checking bench for gate_truth_table_seq. Two instances:
//            dut2 (N_IN=2, HOLD_CYCLES=10) and dut3 (N_IN=3, HOLD_CYCLES=1).
//            A vector table of {instance, op, expected truth table} drives
//            full sweeps; hand sequences cover reset abort, start during
//            a sweep and (when built with GATE_TT_COMPARE_EN) the compare.
// Revision : 1.0  initial release
// ============================================================================
module tb_gate_truth_table_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start2, start3;
    logic [2:0] op2, op3;
    logic       busy2, busy3, done2, done3, y2, y3;
    logic [1:0] in_vec2;
    logic [2:0] in_vec3;
    logic [3:0] tt2;
    logic [7:0] tt3;
`ifdef GATE_TT_COMPARE_EN
    logic [3:0] exp_tt2;
    logic [7:0] exp_tt3;
    logic       mismatch2, mismatch3;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gate_truth_table_seq #(.N_IN(2), .HOLD_CYCLES(10)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .op(op2),
        .busy(busy2), .done(done2), .in_vec(in_vec2), .y(y2),
`ifdef GATE_TT_COMPARE_EN
        .tt(tt2), .expected_tt(exp_tt2), .mismatch(mismatch2)
`else
        .tt(tt2)
`endif
    );

    gate_truth_table_seq #(.N_IN(3), .HOLD_CYCLES(1)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .op(op3),
        .busy(busy3), .done(done3), .in_vec(in_vec3), .y(y3),
`ifdef GATE_TT_COMPARE_EN
        .tt(tt3), .expected_tt(exp_tt3), .mismatch(mismatch3)
`else
        .tt(tt3)
`endif
    );

    typedef struct {
        bit         sel3;
        logic [2:0] op;
        logic [7:0] exp_tt;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Launch a sweep on one instance and watch it cycle by cycle.
    // Cycle 1 is the cycle right after the edge that samples start.
    task automatic run_sweep(input bit sel3, input logic [2:0] opv,
                             input logic [7:0] exp_tt, input string name);
        int run_len, hold, busy_cnt, done_cnt, done_at, walk_err;
        logic b, d;
        logic [2:0] iv;
        hold     = sel3 ? 1 : 10;
        run_len  = sel3 ? 8 : 40;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        walk_err = 0;
        @(negedge clk);
        if (sel3) begin start3 = 1'b1; op3 = opv; end
        else      begin start2 = 1'b1; op2 = opv; end
        @(posedge clk);
        #1;
        start2 = 1'b0;
        start3 = 1'b0;
        for (int k = 1; k <= run_len + 5; k++) begin
            b  = sel3 ? busy3 : busy2;
            d  = sel3 ? done3 : done2;
            iv = sel3 ? in_vec3 : {1'b0, in_vec2};
            if (b) busy_cnt++;
            if (d) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (k <= run_len && iv != 3'((k - 1) / hold)) walk_err++;
            @(posedge clk);
            #1;
        end
        check({name, "_busy_len"}, busy_cnt, run_len);
        check({name, "_done_at"}, done_at, run_len + 1);
        check({name, "_done_cnt"}, done_cnt, 1);
        check({name, "_in_vec_walk"}, walk_err, 0);
        check({name, "_tt"}, sel3 ? {24'd0, tt3} : {28'd0, tt2}, {24'd0, exp_tt});
    endtask

    initial begin
        int done_cnt, busy_cnt;

        // {sel3, op, expected tt}; tt[i] = gate(i)
        vecs[0]  = '{1'b0, 3'd1, 8'b0000_1110};  // OR
        vecs[1]  = '{1'b0, 3'd0, 8'b0000_1000};  // AND
        vecs[2]  = '{1'b0, 3'd3, 8'b0000_0111};  // NAND
        vecs[3]  = '{1'b0, 3'd2, 8'b0000_0110};  // XOR
        vecs[4]  = '{1'b0, 3'd4, 8'b0000_0001};  // NOR
        vecs[5]  = '{1'b0, 3'd5, 8'b0000_1001};  // XNOR
        vecs[6]  = '{1'b0, 3'd6, 8'b0000_1010};  // BUF bit0
        vecs[7]  = '{1'b0, 3'd7, 8'b0000_0101};  // NOT bit0
        vecs[8]  = '{1'b1, 3'd2, 8'b1001_0110};  // XOR
        vecs[9]  = '{1'b1, 3'd0, 8'b1000_0000};  // AND
        vecs[10] = '{1'b1, 3'd1, 8'b1111_1110};  // OR
        vecs[11] = '{1'b1, 3'd3, 8'b0111_1111};  // NAND
        vecs[12] = '{1'b1, 3'd4, 8'b0000_0001};  // NOR
        vecs[13] = '{1'b1, 3'd5, 8'b0110_1001};  // XNOR
        vecs[14] = '{1'b1, 3'd6, 8'b1010_1010};  // BUF bit0
        vecs[15] = '{1'b1, 3'd7, 8'b0101_0101};  // NOT bit0

        rst = 1'b1; start2 = 1'b0; start3 = 1'b0; op2 = 3'd0; op3 = 3'd0;
`ifdef GATE_TT_COMPARE_EN
        exp_tt2 = 4'd0; exp_tt3 = 8'd0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {30'd0, busy2, busy3}, 0);
        check("rst_done", {30'd0, done2, done3}, 0);
        check("rst_in_vec", {27'd0, in_vec2, in_vec3}, 0);
        check("rst_tt", {20'd0, tt2, tt3}, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_sweep(vecs[i].sel3, vecs[i].op, vecs[i].exp_tt, $sformatf("vec%0d", i));
        end

        // Reset abort mid-sweep (OR on dut2), then a clean restart.
        @(negedge clk);
        start2 = 1'b1; op2 = 3'd1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        for (int k = 1; k < 25; k++) begin
            @(posedge clk);
            #1;
        end
        check("abort_pre_in_vec", {30'd0, in_vec2}, 2);
        check("abort_pre_tt", {28'd0, tt2}, 4'b0010);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", {31'd0, busy2}, 0);
        check("abort_tt", {28'd0, tt2}, 0);
        check("abort_in_vec", {30'd0, in_vec2}, 0);
        done_cnt = 0;
        for (int k = 0; k < 50; k++) begin
            if (done2 || busy2) done_cnt++;
            @(posedge clk);
            #1;
        end
        check("abort_no_done", done_cnt, 0);
        run_sweep(1'b0, 3'd1, 8'b0000_1110, "restart");

        // start with a new op during RUN must be ignored and not queued.
        @(negedge clk);
        start2 = 1'b1; op2 = 3'd1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        done_cnt = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 60; k++) begin
            if (k == 12) begin start2 = 1'b1; op2 = 3'd0; end
            if (k == 13) start2 = 1'b0;
            if (done2) done_cnt++;
            if (busy2) busy_cnt++;
            @(posedge clk);
            #1;
        end
        check("ignore_start_tt", {28'd0, tt2}, 4'b1110);
        check("ignore_start_done_cnt", done_cnt, 1);
        check("ignore_start_busy_len", busy_cnt, 40);

`ifdef GATE_TT_COMPARE_EN
        exp_tt2 = 4'b0001;
        run_sweep(1'b0, 3'd4, 8'b0000_0001, "cmp_match");
        check("cmp_match_mismatch", {31'd0, mismatch2}, 0);
        exp_tt2 = 4'b1110;
        @(negedge clk);
        start2 = 1'b1; op2 = 3'd4;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        for (int k = 1; k < 41; k++) begin
            @(posedge clk);
            #1;
        end
        check("cmp_bad_done", {31'd0, done2}, 1);
        check("cmp_bad_mismatch", {31'd0, mismatch2}, 1);
        repeat (10) @(posedge clk);
        #1;
        check("cmp_bad_sticky", {31'd0, mismatch2}, 1);
        exp_tt2 = 4'b0001;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        check("cmp_clear_on_start", {31'd0, mismatch2}, 0);
        repeat (50) @(posedge clk);
        #1;
        check("cmp_rerun_mismatch", {31'd0, mismatch2}, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
